interrupt_controller: RTL and testbench

- Prioritised, nestable interrupt controller for the 5-stage pipelined CPU.
- Synchronises external key inputs and latches them as pending requests.
- Decides when the pipeline may be redirected to a handler vector, and keeps a stack of return PCs for `uret`.
- Sits beside the EX stage: it drives the PC-redirect/flush path and consumes the STI/CLI/URET decode strobes.

---
 rtl/interrupt_controller.sv | 167 ++++++++++++++++
 tb/tb_interrupt_controller.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - prioritised nestable interrupt controller with return-PC stack
module interrupt_controller #(
  parameter int unsigned N          = 3,
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned VEC_BASE   = 'h800,
  parameter int unsigned VEC_STRIDE = 'h100,
  parameter int unsigned HOLDOFF    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     irq_in,
  input  logic             sti,
  input  logic             cli,
  input  logic             uret,
  input  logic             take_ok,
  input  logic [WIDTH-1:0] cur_pc,
  output logic             redirect,
  output logic [WIDTH-1:0] redirect_pc,
  output logic             ie,
  output logic [N-1:0]     pending,
  output logic [N-1:0]     in_service,
  output logic [1:0]       level
);

  typedef enum logic {ST_IDLE, ST_HOLD} state_e;

  localparam logic [N-1:0] ONE_HOT0 = N'(1);

  state_e           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [N-1:0]     sync1_q, sync2_q, prev_q;
  logic [N-1:0]     edge_det;
  logic             ie_q, ie_d;
  logic [N-1:0]     pending_q, pending_d;
  logic [N-1:0]     in_service_q, in_service_d;
  logic [1:0]       level_q, level_d;
  logic             redirect_q, redirect_d;
  logic [WIDTH-1:0] redirect_pc_q, redirect_pc_d;
  logic [WIDTH-1:0] stack_q [N];
  logic             do_push;

  int unsigned      cur;
  int unsigned      cand_idx;
  logic             cand_valid;
  logic [N-1:0]     top_mask;

  // Rising edge of the synchronised key lines; prev_q is the delayed copy.
  assign edge_det = sync2_q & ~prev_q;

  // Current service depth (highest active source + 1) and the best eligible pending source.
  always_comb begin
    cur        = 0;
    top_mask   = '0;
    cand_valid = 1'b0;
    cand_idx   = 0;
    for (int unsigned i = 0; i < N; i++) begin
      if (in_service_q[i]) begin
        cur      = i + 1;
        top_mask = ONE_HOT0 << i;
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (pending_q[i] && (i + 1 > cur)) begin
        cand_valid = 1'b1;
        cand_idx   = i;
      end
    end
  end

  // Redirect decisions in IDLE, holdoff countdown in HOLD, enable and pending bookkeeping.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;
    pending_d     = pending_q | edge_det;
    in_service_d  = in_service_q;
    level_d       = level_q;
    do_push       = 1'b0;
    ie_d          = ie_q;

    if (cli) begin
      ie_d = 1'b0;
    end else if (sti) begin
      ie_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (uret && (level_q != 2'd0)) begin
          redirect_d    = 1'b1;
          redirect_pc_d = stack_q[level_q - 2'd1];
          level_d       = level_q - 2'd1;
          in_service_d  = in_service_q & ~top_mask;
          state_d       = ST_HOLD;
          cnt_d         = 3'(HOLDOFF - 1);
        end else if (ie_q && cand_valid && take_ok && !uret) begin
          redirect_d    = 1'b1;
          redirect_pc_d = WIDTH'(VEC_BASE + cand_idx * VEC_STRIDE);
          do_push       = 1'b1;
          level_d       = level_q + 2'd1;
          in_service_d  = in_service_q | (ONE_HOT0 << cand_idx);
          // A same-cycle edge on the taken source is deliberately lost.
          pending_d     = pending_d & ~(ONE_HOT0 << cand_idx);
          state_d       = ST_HOLD;
          cnt_d         = 3'(HOLDOFF - 1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == 3'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, synchronisers and architectural registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      sync1_q       <= '0;
      sync2_q       <= '0;
      prev_q        <= '0;
      ie_q          <= 1'b0;
      pending_q     <= '0;
      in_service_q  <= '0;
      level_q       <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sync1_q       <= irq_in;
      sync2_q       <= sync1_q;
      prev_q        <= sync2_q;
      ie_q          <= ie_d;
      pending_q     <= pending_d;
      in_service_q  <= in_service_d;
      level_q       <= level_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  // Return-PC stack; the slot at the current depth receives the interrupted PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < N; k++) begin
        stack_q[k] <= '0;
      end
    end else if (do_push) begin
      stack_q[level_q] <= cur_pc;
    end
  end

  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;
  assign ie          = ie_q;
  assign pending     = pending_q;
  assign in_service  = in_service_q;
  assign level       = level_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// tb/tb_interrupt_controller.sv - scoreboard bench for interrupt_controller
module tb_interrupt_controller;

  localparam int N          = 3;
  localparam int WIDTH      = 32;
  localparam int VEC_BASE   = 'h800;
  localparam int VEC_STRIDE = 'h100;
  localparam int HOLDOFF    = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     irq_in = '0;
  logic             sti = 1'b0, cli = 1'b0, uret = 1'b0, take_ok = 1'b0;
  logic [WIDTH-1:0] cur_pc = '0;
  logic             redirect;
  logic [WIDTH-1:0] redirect_pc;
  logic             ie;
  logic [N-1:0]     pending;
  logic [N-1:0]     in_service;
  logic [1:0]       level;

  always #5 clk = ~clk;

  interrupt_controller #(
    .N(N), .WIDTH(WIDTH), .VEC_BASE(VEC_BASE), .VEC_STRIDE(VEC_STRIDE), .HOLDOFF(HOLDOFF)
  ) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .sti(sti), .cli(cli), .uret(uret),
    .take_ok(take_ok), .cur_pc(cur_pc), .redirect(redirect), .redirect_pc(redirect_pc),
    .ie(ie), .pending(pending), .in_service(in_service), .level(level)
  );

  typedef struct {
    logic        redirect;
    logic [31:0] pc;
    logic        ie;
    logic [2:0]  pend;
    logic [2:0]  insvc;
    logic [1:0]  lvl;
  } snap_t;

  snap_t exp_q[$];
  int    vectors     = 0;
  int    miscompares = 0;

  // Reference model: key history, pending set, stack of serviced sources and saved PCs.
  logic [2:0]  m_hist[$];
  logic        m_ie;
  logic [2:0]  m_pend;
  int          m_svc[$];
  logic [31:0] m_pcs[$];
  logic [31:0] m_last_pc;
  int          m_busy;
  logic [2:0]  irq_lvl;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
    if (got !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_hist.delete();
    repeat (4) m_hist.push_back(3'b000);
    m_ie      = 1'b0;
    m_pend    = 3'b000;
    m_svc.delete();
    m_pcs.delete();
    m_last_pc = '0;
    m_busy    = 0;
  endtask

  task automatic step(input logic [2:0] irq, input logic s, input logic c,
                      input logic u, input logic t, input logic [31:0] pc);
    snap_t      e;
    logic [2:0] edges;
    logic [2:0] ins;
    int         cur;
    int         cand;
    bit         redir;
    bit         tk;
    @(negedge clk);
    irq_in  = irq;
    sti     = s;
    cli     = c;
    uret    = u;
    take_ok = t;
    cur_pc  = pc;

    m_hist.push_front(irq);
    void'(m_hist.pop_back());
    edges = m_hist[2] & ~m_hist[3];

    cur = 0;
    foreach (m_svc[j]) if (m_svc[j] + 1 > cur) cur = m_svc[j] + 1;
    cand = -1;
    for (int i = 0; i < N; i++) if (m_pend[i] && (i + 1 > cur)) cand = i;

    redir = 1'b0;
    tk    = 1'b0;
    if (m_busy == 0 && u && m_svc.size() > 0) begin
      redir     = 1'b1;
      m_last_pc = m_pcs.pop_back();
      void'(m_svc.pop_back());
    end else if (m_busy == 0 && m_ie && cand >= 0 && t && !u) begin
      redir     = 1'b1;
      tk        = 1'b1;
      m_last_pc = 32'(VEC_BASE + cand * VEC_STRIDE);
      m_pcs.push_back(pc);
      m_svc.push_back(cand);
    end
    m_pend = m_pend | edges;
    if (tk) m_pend = m_pend & ~(3'b001 << cand);
    if (c) m_ie = 1'b0;
    else if (s) m_ie = 1'b1;
    if (redir) m_busy = HOLDOFF;
    else if (m_busy > 0) m_busy--;

    ins = 3'b000;
    foreach (m_svc[j]) ins = ins | (3'b001 << m_svc[j]);
    e.redirect = redir;
    e.pc       = m_last_pc;
    e.ie       = m_ie;
    e.pend     = m_pend;
    e.insvc    = ins;
    e.lvl      = 2'(m_svc.size());
    exp_q.push_back(e);
    vectors++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(irq_lvl, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100 + 32'(k * 4));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " redirect"}, 32'(redirect), 32'd0);
    chk({tag, " redirect_pc"}, redirect_pc, 32'd0);
    chk({tag, " ie"}, 32'(ie), 32'd0);
    chk({tag, " pending"}, 32'(pending), 32'd0);
    chk({tag, " in_service"}, 32'(in_service), 32'd0);
    chk({tag, " level"}, 32'(level), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async reset");
    irq_in  = '0; sti = 1'b0; cli = 1'b0; uret = 1'b0; take_ok = 1'b0;
    irq_lvl = 3'b000;
    model_reset();
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: every cycle the DUT outputs are popped against the expected snapshot.
  initial begin
    snap_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("redirect", 32'(redirect), 32'(e.redirect));
        chk("redirect_pc", redirect_pc, e.pc);
        chk("ie", 32'(ie), 32'(e.ie));
        chk("pending", 32'(pending), 32'(e.pend));
        chk("in_service", 32'(in_service), 32'(e.insvc));
        chk("level", 32'(level), 32'(e.lvl));
      end else if (!rst && redirect) begin
        miscompares++;
        $display("FAIL unexpected redirect: got 1 expected 0 at %0t", $time);
      end
    end
  end

  initial begin
    model_reset();
    irq_lvl = 3'b000;
    #3;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Single interrupt and return.
    step(irq_lvl, 1'b1, 1'b0, 1'b0, 1'b1, 32'h40);
    irq_lvl = 3'b001;
    for (int k = 0; k < 6; k++) step(irq_lvl, 1'b0, 1'b0, 1'b0, 1'b1, 32'h40);
    step(irq_lvl, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
    irq_lvl = 3'b000;
    idle(5);

    // Nesting: source 2 preempts source 0.
    irq_lvl = 3'b001;
    idle(6);
    irq_lvl = 3'b101;
    for (int k = 0; k < 6; k++) step(irq_lvl, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1234);
    step(irq_lvl, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
    idle(4);
    step(irq_lvl, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
    irq_lvl = 3'b000;
    idle(4);

    // Priority with ie=0 first.
    step(irq_lvl, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
    irq_lvl = 3'b011;
    idle(6);
    step(irq_lvl, 1'b1, 1'b0, 1'b0, 1'b1, 32'h200);
    idle(8);
    step(irq_lvl, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
    idle(6);
    step(irq_lvl, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
    irq_lvl = 3'b000;
    idle(4);

    // Gating by take_ok and a second candidate arriving during HOLD.
    irq_lvl = 3'b001;
    for (int k = 0; k < 8; k++) step(irq_lvl, 1'b0, 1'b0, 1'b0, 1'b0, 32'h300);
    irq_lvl = 3'b101;
    step(irq_lvl, 1'b0, 1'b0, 1'b0, 1'b0, 32'h300);
    step(irq_lvl, 1'b0, 1'b0, 1'b0, 1'b1, 32'h304);
    idle(8);
    step(irq_lvl, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
    idle(4);
    step(irq_lvl, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
    irq_lvl = 3'b000;
    idle(4);

    // Corner cases: sti+cli, uret at level 0, uret racing a candidate.
    step(irq_lvl, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0);
    step(irq_lvl, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
    step(irq_lvl, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
    irq_lvl = 3'b001;
    idle(6);
    irq_lvl = 3'b011;
    for (int k = 0; k < 5; k++) step(irq_lvl, 1'b0, 1'b0, 1'b0, 1'b0, 32'h500);
    step(irq_lvl, 1'b0, 1'b0, 1'b1, 1'b1, 32'h504);
    idle(8);
    step(irq_lvl, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
    irq_lvl = 3'b000;
    idle(4);

    // Reset at nesting depth 2, then a key edge is held off until sti.
    irq_lvl = 3'b001;
    idle(6);
    irq_lvl = 3'b101;
    idle(6);
    do_reset();
    irq_lvl = 3'b001;
    idle(8);
    step(irq_lvl, 1'b1, 1'b0, 1'b0, 1'b1, 32'h600);
    idle(4);
    step(irq_lvl, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
    idle(4);

    // Randomised traffic.
    for (int k = 0; k < 3000; k++) begin
      logic [2:0] flip;
      flip[0] = ($urandom_range(0, 7) == 0);
      flip[1] = ($urandom_range(0, 7) == 0);
      flip[2] = ($urandom_range(0, 7) == 0);
      irq_lvl = irq_lvl ^ flip;
      step(irq_lvl, ($urandom_range(0, 5) == 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0), $urandom & 32'hFFFF_FFFC);
    end
    idle(3);
    @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
